ctrl_decode_stage: RTL

//  Registered, parametrised successor to the combinational control unit; sits between fetch and execute.

---
 rtl/ctrl_decode_stage.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_decode_stage.sv
// RV32I control decode stage: registered decode into a 2-entry FIFO skid buffer with flush and sticky HALTED.
// Optional macro CTRL_MEXT_EN enables MUL decode (opcode 33, funct7=01, funct3=000).
module ctrl_decode_stage #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [3:0]        alu_op,
  output logic              reg_wr,
  output logic              dwen,
  output logic              dren,
  output logic              alu_src,
  output logic              jp_sel,
  output logic [1:0]        pc_src,
  output logic [2:0]        rd_sel,
  output logic [IMM_W-1:0]  imm,
  output logic              illegal,
  output logic              halt,
  output logic [0:0]        dbg_state
);

  // Handshake: a beat is accepted when in_valid && in_ready && !flush; the head retires when out_valid && out_ready.
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
`ifdef CTRL_MEXT_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_op;
    logic              reg_wr;
    logic              dwen;
    logic              dren;
    logic              alu_src;
    logic              jp_sel;
    logic [1:0]        pc_src;
    logic [2:0]        rd_sel;
    logic [IMM_W-1:0]  imm;
    logic              illegal;
    logic              halt;
  } dec_t;

  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (alt && is_r) ? OP_SUB : OP_ADD;
      3'd1:    op = OP_SLL;
      3'd2:    op = OP_SLT;
      3'd3:    op = OP_SLTU;
      3'd4:    op = OP_XOR;
      3'd5:    op = alt ? OP_SRA : OP_SRL;
      3'd6:    op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [31:0] w);
    dec_t        d;
    logic [31:0] imm32;
    logic [2:0]  f3;
    logic [6:0]  f7;
    d     = '0;
    imm32 = '0;
    f3    = w[14:12];
    f7    = w[31:25];
    d.rs1 = REG_AW'(w[19:15]);
    d.rs2 = REG_AW'(w[24:20]);
    d.rd  = REG_AW'(w[11:7]);
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h01) begin
`ifdef CTRL_MEXT_EN
          if (f3 == 3'b000) begin
            d.reg_wr = 1'b1;
            d.alu_op = OP_MUL;
          end else begin
            d.illegal = 1'b1;
          end
`else
          d.illegal = 1'b1;
`endif
        end else begin
          d.reg_wr = 1'b1;
          d.alu_op = alu_f3(f3, f7[5], 1'b1);
        end
      end
      7'h13: begin
        d.reg_wr  = 1'b1;
        d.alu_src = 1'b1;
        d.alu_op  = alu_f3(f3, f7[5], 1'b0);
        imm32     = {{20{w[31]}}, w[31:20]};
      end
      7'h03: begin
        d.reg_wr  = 1'b1;
        d.dren    = 1'b1;
        d.alu_src = 1'b1;
        d.rd_sel  = 3'd1;
        imm32     = {{20{w[31]}}, w[31:20]};
      end
      7'h23: begin
        d.dwen    = 1'b1;
        d.alu_src = 1'b1;
        imm32     = {{20{w[31]}}, w[31:25], w[11:7]};
      end
      7'h63: begin
        d.pc_src = 2'd1;
        d.alu_op = f3[2] ? (f3[1] ? OP_SLTU : OP_SLT) : OP_SUB;
        imm32    = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      7'h6F: begin
        d.reg_wr = 1'b1;
        d.jp_sel = 1'b1;
        d.pc_src = 2'd2;
        d.rd_sel = 3'd2;
        imm32    = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      7'h67: begin
        d.reg_wr  = 1'b1;
        d.jp_sel  = 1'b1;
        d.alu_src = 1'b1;
        d.pc_src  = 2'd3;
        d.rd_sel  = 3'd2;
        imm32     = {{20{w[31]}}, w[31:20]};
      end
      7'h37: begin
        d.reg_wr = 1'b1;
        d.rd_sel = 3'd3;
        imm32    = {{12{w[31]}}, w[31:12]};
      end
      7'h17: begin
        d.reg_wr = 1'b1;
        d.rd_sel = 3'd4;
        imm32    = {{12{w[31]}}, w[31:12]};
      end
      7'h7F:   d.halt    = 1'b1;
      default: d.illegal = 1'b1;
    endcase
    d.imm = IMM_W'($signed(imm32));
    return d;
  endfunction

  dec_t       ent0, ent1, e0_n, e1_n, nd, head;
  logic [1:0] cnt, cnt_n;
  logic [0:0] state, state_n;
  logic       accept, retire, halt_retire;

  assign nd          = decode(instr[31:0]);
  assign out_valid   = (cnt != 2'd0) && (state == RUN);
  assign accept      = in_valid && in_ready && !flush;
  assign retire      = out_valid && out_ready;
  assign halt_retire = retire && ent0.halt;
  assign state_n     = halt_retire ? HALTED : state;
  assign dbg_state   = state;

  // Shift-style FIFO: ent0 is always the head, ent1 the entry behind it.
  always_comb begin
    e0_n  = ent0;
    e1_n  = ent1;
    cnt_n = cnt;
    if (flush || halt_retire) begin
      cnt_n = 2'd0;
    end else begin
      if (retire) begin
        e0_n  = ent1;
        cnt_n = cnt - 2'd1;
      end
      if (accept) begin
        if (cnt_n == 2'd0) e0_n = nd;
        else               e1_n = nd;
        cnt_n = cnt_n + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 2'd0;
      ent0     <= '0;
      ent1     <= '0;
      state    <= RUN;
      in_ready <= 1'b1;
    end else begin
      cnt      <= cnt_n;
      ent0     <= e0_n;
      ent1     <= e1_n;
      state    <= state_n;
      in_ready <= (cnt_n < 2'd2) && (state_n == RUN);
    end
  end

  // Stale entry data stays in the registers; gating on out_valid keeps every output at zero when empty.
  assign head    = out_valid ? ent0 : '0;
  assign rs1     = head.rs1;
  assign rs2     = head.rs2;
  assign rd      = head.rd;
  assign alu_op  = head.alu_op;
  assign reg_wr  = head.reg_wr;
  assign dwen    = head.dwen;
  assign dren    = head.dren;
  assign alu_src = head.alu_src;
  assign jp_sel  = head.jp_sel;
  assign pc_src  = head.pc_src;
  assign rd_sel  = head.rd_sel;
  assign imm     = head.imm;
  assign illegal = head.illegal;
  assign halt    = head.halt;

endmodule
